// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared definitions for the sequential shift-add multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int WIDTH_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t CALC   = 2'd1;
    localparam state_t DONE_S = 2'd2;

    // Iteration counter width: enough to hold WIDTH with one spare bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rca_add.sv
// ============================================================================
// Module : rca_add
// Brief  : WIDTH-bit ripple-carry adder built from full-adder cells.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_add
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign S[i]       = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// Module : mult_seq_ctrl
// Brief  : Sequential shift-add unsigned multiplier, one adder over WIDTH steps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int                 CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

    state_t                state;
    state_t                state_nxt;

    logic [WIDTH-1:0]      m;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      a;
    logic                  c;
    logic [CNT_W-1:0]      cnt;
    logic [2*WIDTH-1:0]    prod;

    logic [WIDTH-1:0]      addend;
    logic [WIDTH-1:0]      sum;
    logic                  cout;
    logic                  accept;
    logic                  last_iter;

    assign accept    = START && ((state == IDLE) || (state == DONE_S));
    assign last_iter = (cnt == LAST_ITER);
    assign addend    = q[0] ? m : '0;

    // c is zero at the start of every iteration (cleared on load and by the
    // shift), so feeding it as carry-in leaves the sum equal to A + addend.
    rca_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .A    (a),
        .B    (addend),
        .Cin  (c),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = START ? CALC : IDLE;
            CALC:    state_nxt = last_iter ? DONE_S : CALC;
            DONE_S:  state_nxt = START ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == CALC);
        DONE = (state == DONE_S);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            m    <= '0;
            q    <= '0;
            a    <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            prod <= '0;
        end else if (accept) begin
            m   <= X;
            q   <= Y;
            a   <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else if (state == CALC) begin
            // Add then shift {cout,sum,q} right by one in a single edge.
            a   <= {cout, sum[WIDTH-1:1]};
            q   <= {sum[0], q[WIDTH-1:1]};
            c   <= 1'b0;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                prod <= {cout, sum, q[WIDTH-1:1]};
            end
        end
    end

    assign Z = prod;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// Module : tb_mult_seq_ctrl
// Brief  : Self-checking bench for mult_seq_ctrl against an X*Y model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl;

    localparam int W  = 4;
    localparam int ZW = 2 * W;

    logic          CLK;
    logic          RST;
    logic          START;
    logic [W-1:0]  X;
    logic [W-1:0]  Y;
    logic          BUSY;
    logic          DONE;
    logic [ZW-1:0] Z;

    int            n_checks;
    int            n_fail;
    logic [ZW-1:0] z_prev;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [ZW-1:0] z;
    } vec_t;

    vec_t vecs[8];

    mult_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .X     (X),
        .Y     (Y),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Z     (Z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One complete operation; optional noise on START/X/Y while it runs.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [ZW-1:0] exp_z, input bit noisy);
        int            done_k;
        int            busy_n;
        int            extra_done;
        bit            z_moved;
        logic [ZW-1:0] z_at_done;
        done_k     = -1;
        busy_n     = 0;
        extra_done = 0;
        z_moved    = 1'b0;
        z_at_done  = '0;
        @(negedge CLK);
        START = 1'b1;
        X     = x;
        Y     = y;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) begin
                if (done_k < 0) begin
                    done_k    = k;
                    z_at_done = Z;
                end else begin
                    extra_done++;
                end
            end else if (done_k < 0 && Z != z_prev) begin
                z_moved = 1'b1;
            end
            START = (noisy && k <= W) ? 1'($urandom) : 1'b0;
            X     = W'($urandom);
            Y     = W'($urandom);
        end
        check("latency_edges", done_k - 1, W);
        check("busy_cycles", busy_n, W);
        check("z_product", int'(z_at_done), int'(exp_z));
        check("z_hold_during_calc", int'(z_moved), 0);
        check("single_done_pulse", extra_done, 0);
        z_prev = exp_z;
    endtask

    initial begin
        int            d1, d2, extra, dn;
        bit            held_ok;
        logic [ZW-1:0] z1, z2;

        n_checks = 0;
        n_fail   = 0;
        z_prev   = '0;

        vecs[0] = '{x: 4'd15, y: 4'd15, z: 8'd225};
        vecs[1] = '{x: 4'd0,  y: 4'd9,  z: 8'd0};
        vecs[2] = '{x: 4'd9,  y: 4'd0,  z: 8'd0};
        vecs[3] = '{x: 4'd1,  y: 4'd1,  z: 8'd1};
        vecs[4] = '{x: 4'd15, y: 4'd1,  z: 8'd15};
        vecs[5] = '{x: 4'd1,  y: 4'd15, z: 8'd15};
        vecs[6] = '{x: 4'd10, y: 4'd13, z: 8'd130};
        vecs[7] = '{x: 4'd8,  y: 4'd8,  z: 8'd64};

        // Reset must win over a pending START.
        RST   = 1'b1;
        START = 1'b1;
        X     = 4'd15;
        Y     = 4'd15;
        repeat (3) @(negedge CLK);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_z", int'(Z), 0);
        RST   = 1'b0;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_stays_idle", int'(BUSY), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].z, 1'b0);
        end

        // Second START during CALC is ignored.
        @(negedge CLK);
        START = 1'b1; X = 4'd1; Y = 4'd9;
        dn = 0; d1 = -1; z1 = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (DONE) begin
                dn++;
                if (d1 < 0) begin d1 = k; z1 = Z; end
            end
            if (k == 2) begin START = 1'b1; X = 4'd7; Y = 4'd3; end
            else        begin START = 1'b0; end
        end
        check("ignored_start_done_count", dn, 1);
        check("ignored_start_latency", d1 - 1, W);
        check("ignored_start_z", int'(z1), 9);
        z_prev = 8'd9;

        // START held high: back-to-back results.
        @(negedge CLK);
        START = 1'b1; X = 4'd3; Y = 4'd5;
        d1 = -1; d2 = -1; extra = 0; held_ok = 1'b1; z1 = '0; z2 = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (DONE) begin
                if (d1 < 0)      begin d1 = k; z1 = Z; end
                else if (d2 < 0) begin d2 = k; z2 = Z; end
                else             extra++;
            end else if (d1 > 0 && d2 < 0 && Z != 8'd15) begin
                held_ok = 1'b0;
            end
            if (k == 1)      begin X = 4'd12; Y = 4'd11; end
            else if (k >= 6) begin X = W'($urandom); Y = W'($urandom); end
            if (k == 10) START = 1'b0;
        end
        check("b2b_first_latency", d1 - 1, W);
        check("b2b_first_z", int'(z1), 15);
        check("b2b_spacing", d2 - d1, W + 1);
        check("b2b_second_z", int'(z2), 132);
        check("b2b_z_held", int'(held_ok), 1);
        check("b2b_no_extra_done", extra, 0);
        z_prev = 8'd132;

        // Reset two cycles into CALC aborts the operation.
        @(negedge CLK);
        START = 1'b1; X = 4'd13; Y = 4'd11;
        @(negedge CLK);
        START = 1'b0;
        check("abort_busy_before", int'(BUSY), 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        check("abort_z", int'(Z), 0);
        RST = 1'b0;
        dn  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (DONE) dn++;
        end
        check("abort_no_done", dn, 0);
        z_prev = '0;
        run_op(4'd6, 4'd7, 8'd42, 1'b0);

        // Exhaustive sweep with noise on the inputs while busy.
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] xi, yi;
            xi = W'(i >> W);
            yi = W'(i);
            run_op(xi, yi, ZW'(int'(xi) * int'(yi)), 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] xr, yr;
            xr = W'($urandom);
            yr = W'($urandom);
            run_op(xr, yr, ZW'(int'(xr) * int'(yr)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
